// File: rtl/canny_pkg.sv
// Shared types and window packing helpers for the Canny front end.
package canny_pkg;

  localparam int COL_DEPTH = 8;
  localparam int WIN_TAPS  = 9;

  typedef logic [COL_DEPTH-1:0]          pixel_t;
  typedef logic [WIN_TAPS*COL_DEPTH-1:0] window_t;

  // Low bit of element (r,c); element 0 (top-left) sits in the MSBs.
  function automatic int unsigned win_idx(input int unsigned r,
                                          input int unsigned c,
                                          input int unsigned depth = COL_DEPTH);
    return (WIN_TAPS - 1 - (3 * r + c)) * depth;
  endfunction

endpackage

// File: rtl/window_3x3_linebuf_line_buffer.sv
// Single-port row memory: combinational read of the old word, synchronous write.
module line_buffer #(
  parameter  int DEPTH = 512,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (en_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/window_3x3_linebuf.sv
// Raster-order pixel stream to packed 3x3 neighbourhoods using two row buffers.
module window_3x3_linebuf
  import canny_pkg::*;
#(
  parameter  int COL_DEPTH  = canny_pkg::COL_DEPTH,
  parameter  int IMG_WIDTH  = 512,
  parameter  int IMG_HEIGHT = 512,
  localparam int CW         = $clog2(IMG_WIDTH),
  localparam int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COL_DEPTH-1:0]          pixel_in,
  input  logic                          pixel_sof,
  input  logic                          pixel_valid,
  output logic                          pixel_ready,
  output logic [WIN_TAPS*COL_DEPTH-1:0] window_out,
  output logic                          window_valid,
  input  logic                          window_ready,
  output logic [CW-1:0]                 center_col,
  output logic [RW-1:0]                 center_row,
  output logic                          frame_done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIN  = CW'(IMG_WIDTH - 2);
  localparam logic [RW-1:0] ROW_FIN  = RW'(IMG_HEIGHT - 2);

  logic [CW-1:0]                 col_q, col_d, cur_col;
  logic [RW-1:0]                 row_q, row_d, cur_row;
  logic [COL_DEPTH-1:0]          lb0_rd, lb1_rd;
  logic [COL_DEPTH-1:0]          sh_q [3][3];
  logic [COL_DEPTH-1:0]          sh_d [3][3];
  logic [WIN_TAPS*COL_DEPTH-1:0] win_pack;
  logic [WIN_TAPS*COL_DEPTH-1:0] window_q, window_d;
  logic                          win_valid_q, win_valid_d;
  logic [CW-1:0]                 ccol_q, ccol_d;
  logic [RW-1:0]                 crow_q, crow_d;
  logic                          frame_done_q, frame_done_d;
  logic                          accept, emit;

  assign pixel_ready = !win_valid_q || window_ready;
  assign accept      = pixel_valid && pixel_ready;

  // A start-of-frame pixel is placed at (0,0) regardless of the counters.
  assign cur_col = pixel_sof ? '0 : col_q;
  assign cur_row = pixel_sof ? '0 : row_q;
  assign emit    = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(COL_DEPTH)) u_lb0 (
    .clk     (clk),
    .en_i    (accept),
    .addr_i  (cur_col),
    .wdata_i (lb1_rd),
    .rdata_o (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(COL_DEPTH)) u_lb1 (
    .clk     (clk),
    .en_i    (accept),
    .addr_i  (cur_col),
    .wdata_i (pixel_in),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        sh_d[r][c] = sh_q[r][c];
      end
    end
    if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 2; c++) begin
          sh_d[r][c] = sh_q[r][c+1];
        end
      end
      sh_d[0][2] = lb0_rd;
      sh_d[1][2] = lb1_rd;
      sh_d[2][2] = pixel_in;
    end
    win_pack = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        win_pack[win_idx(r, c, COL_DEPTH) +: COL_DEPTH] = sh_d[r][c];
      end
    end
  end

  always_comb begin
    win_valid_d  = win_valid_q;
    window_d     = window_q;
    ccol_d       = ccol_q;
    crow_d       = crow_q;
    frame_done_d = win_valid_q && window_ready && (crow_q == ROW_FIN) && (ccol_q == COL_FIN);
    if (emit) begin
      win_valid_d = 1'b1;
      window_d    = win_pack;
      ccol_d      = cur_col - 1'b1;
      crow_d      = cur_row - 1'b1;
    end else if (window_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      window_q     <= '0;
      ccol_q       <= '0;
      crow_q       <= '0;
      frame_done_q <= 1'b0;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          sh_q[r][c] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      window_q     <= window_d;
      ccol_q       <= ccol_d;
      crow_q       <= crow_d;
      frame_done_q <= frame_done_d;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          sh_q[r][c] <= sh_d[r][c];
        end
      end
    end
  end

  assign window_valid = win_valid_q;
  assign window_out   = window_q;
  assign center_col   = ccol_q;
  assign center_row   = crow_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_window_3x3_linebuf.sv
// Randomized bench for window_3x3_linebuf against an image-array reference model.
module tb_window_3x3_linebuf;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CD = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CD-1:0] pixel_in = '0;
  logic          pixel_sof = 1'b0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready;
  logic [71:0]   window_out;
  logic          window_valid;
  logic          window_ready;
  logic [1:0]    center_col;
  logic [1:0]    center_row;
  logic          frame_done;

  window_3x3_linebuf #(.COL_DEPTH(CD), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_in     (pixel_in),
    .pixel_sof    (pixel_sof),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .window_out   (window_out),
    .window_valid (window_valid),
    .window_ready (window_ready),
    .center_col   (center_col),
    .center_row   (center_row),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    int unsigned r;
    int unsigned c;
  } exp_t;

  exp_t        exp_q[$];
  logic [71:0] got_q[$];
  logic [71:0] t1_wins[$];
  logic [7:0]  img [H][W];
  int unsigned mr, mc;
  int unsigned n_tests, n_fail, n_fd_dut;
  logic        fd_pend, stall_prev;
  logic [71:0] prev_win, w_m;
  exp_t        e_m;
  int unsigned rmode, stall_left;
  bit          armed;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: place each accepted pixel in an image array, cut windows from it.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      mr = 0; mc = 0;
      fd_pend = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check_eq("frame_done", 72'(frame_done), 72'(fd_pend));
      if (frame_done) n_fd_dut++;
      check_eq("pixel_ready", 72'(pixel_ready), 72'(!window_valid || window_ready));
      if (stall_prev) begin
        check_eq("hold_window", window_out, prev_win);
        check_eq("hold_valid", 72'(window_valid), 72'd1);
      end
      fd_pend = 1'b0;
      if (window_valid && window_ready) begin
        got_q.push_back(window_out);
        if (exp_q.size() == 0) begin
          check_eq("spurious_window", 72'(window_valid), 72'd0);
        end else begin
          e_m = exp_q.pop_front();
          check_eq("window", window_out, e_m.win);
          check_eq("center_row", 72'(center_row), 72'(e_m.r));
          check_eq("center_col", 72'(center_col), 72'(e_m.c));
          fd_pend = (e_m.r == H - 2) && (e_m.c == W - 2);
        end
      end
      stall_prev = window_valid && !window_ready;
      prev_win   = window_out;
      if (pixel_valid && pixel_ready) begin
        if (pixel_sof) begin mr = 0; mc = 0; end
        img[mr][mc] = pixel_in;
        if (mr >= 2 && mc >= 2) begin
          w_m = '0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              w_m = {w_m[63:0], img[mr-2+r][mc-2+c]};
          exp_q.push_back('{win: w_m, r: mr - 1, c: mc - 1});
        end
        if (mc == W - 1) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
          mc++;
        end
      end
    end
  end

  // Downstream ready: 0 always on, 1 random, 2 one 5-cycle stall at the next window.
  initial begin
    window_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1: window_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (armed && window_valid) begin armed = 1'b0; stall_left = 5; end
          window_ready = (stall_left == 0);
          if (stall_left != 0) stall_left--;
        end
        default: window_ready = 1'b1;
      endcase
    end
  end

  task automatic push_pixel(input logic [7:0] d, input logic s, input int unsigned gap);
    pixel_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    pixel_in = d; pixel_sof = s; pixel_valid = 1'b1;
    for (int unsigned t = 0; t < 200; t++) begin
      @(negedge clk);
      if (pixel_ready) begin
        @(posedge clk); #1;
        pixel_valid = 1'b0; pixel_sof = 1'b0;
        return;
      end
    end
    check_eq("push_timeout", 72'(pixel_ready), 72'd1);
    pixel_valid = 1'b0; pixel_sof = 1'b0;
  endtask

  function automatic int unsigned gap_of(input int unsigned gm);
    if (gm == 1) return 1;
    if (gm == 2) return $urandom_range(0, 2);
    return 0;
  endfunction

  task automatic drain();
    int unsigned t = 0;
    pixel_valid = 1'b0;
    while ((exp_q.size() != 0 || window_valid) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check_eq("drain_timeout", 72'(exp_q.size() != 0 || window_valid), 72'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic start_test();
    got_q.delete();
    n_fd_dut = 0;
  endtask

  task automatic end_test(input string tag, input int unsigned nwin, input int unsigned nfd);
    drain();
    check_eq({tag, "_windows"}, 72'(got_q.size()), 72'(nwin));
    check_eq({tag, "_frame_done"}, 72'(n_fd_dut), 72'(nfd));
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 72'(window_valid), 72'd0);
    check_eq("rst_frame_done", 72'(frame_done), 72'd0);
    check_eq("rst_window", window_out, 72'd0);
    check_eq("rst_center", 72'({center_row, center_col}), 72'd0);
    @(posedge clk); #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; rmode = 0; armed = 1'b0; stall_left = 0;
    @(posedge clk); #1;
    do_reset();

    // Continuous ramp, downstream always ready.
    start_test();
    for (int i = 0; i < 16; i++) push_pixel(8'(i), 1'b0, 0);
    end_test("ramp", 4, 1);
    if (got_q.size() == 4) begin
      check_eq("ramp_first", got_q[0], 72'h00010204050608090A);
      check_eq("ramp_last", got_q[3], 72'h050607090A0B0D0E0F);
    end
    t1_wins = got_q;

    // Same ramp with a 5-cycle downstream stall on the first window.
    rmode = 2; armed = 1'b1; stall_left = 0;
    start_test();
    for (int i = 0; i < 16; i++) push_pixel(8'(i), 1'b0, 0);
    end_test("stall", 4, 1);
    if (got_q.size() == 4) check_eq("stall_first", got_q[0], 72'h00010204050608090A);
    rmode = 0;

    // Valid toggling every cycle.
    start_test();
    for (int i = 0; i < 16; i++) push_pixel(8'(i), 1'b0, 1);
    end_test("toggle", 4, 1);
    for (int i = 0; i < 4; i++)
      if (got_q.size() == 4 && t1_wins.size() == 4) check_eq("toggle_seq", got_q[i], t1_wins[i]);

    // Reset mid-frame, then a flat 0x80 frame.
    for (int i = 0; i < 7; i++) push_pixel(8'($urandom_range(0, 255)), 1'b0, 0);
    do_reset();
    start_test();
    for (int i = 0; i < 16; i++) push_pixel(8'h80, 1'b0, 0);
    end_test("post_reset", 4, 1);
    foreach (got_q[i]) check_eq("post_reset_win", got_q[i], {9{8'h80}});

    // SOF on the 6th pixel realigns the counters.
    start_test();
    for (int i = 0; i < 5; i++) push_pixel(8'($urandom_range(0, 255)), 1'b0, 0);
    push_pixel(8'h10, 1'b1, 0);
    for (int i = 0; i < 15; i++) push_pixel(8'h10, 1'b0, 0);
    end_test("sof", 4, 1);
    foreach (got_q[i]) check_eq("sof_win", got_q[i], {9{8'h10}});

    // Two back-to-back frames, random data, gaps and backpressure.
    rmode = 1;
    start_test();
    for (int i = 0; i < 16; i++) push_pixel(8'($urandom_range(0, 127)), i == 0, gap_of(2));
    for (int i = 0; i < 16; i++) push_pixel(8'h80 | 8'($urandom_range(0, 127)), i == 0, gap_of(2));
    end_test("b2b", 8, 2);
    if (got_q.size() == 8) check_eq("b2b_no_stale", got_q[4] & {9{8'h80}}, {9{8'h80}});

    // Random soak over several frames.
    start_test();
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 16; i++)
        push_pixel(8'($urandom_range(0, 255)), 1'b0, gap_of($urandom_range(0, 2)));
    end_test("soak", 16, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
